// File: rtl/vip_ycbcr_share_arb.sv
// Time-shares one fixed-latency RGB->YCbCr converter between two pixel sources.
// Per-beat bounded-burst round-robin grant; a tag pipeline routes results back to their requester.
module vip_ycbcr_share_arb #(
  parameter int LATENCY = 3,
  parameter int BURST   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_rgb,
  input  logic [1:0]  req0_user,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_rgb,
  input  logic [1:0]  req1_user,
  output logic        cvt_vsync,
  output logic        cvt_href,
  output logic        cvt_clken,
  output logic [7:0]  cvt_red,
  output logic [7:0]  cvt_green,
  output logic [7:0]  cvt_blue,
  input  logic        cvt_post_clken,
  input  logic [7:0]  cvt_Y,
  input  logic [7:0]  cvt_Cb,
  input  logic [7:0]  cvt_Cr,
  output logic        rsp0_valid,
  output logic [23:0] rsp0_ycbcr,
  output logic [1:0]  rsp0_user,
  output logic        rsp1_valid,
  output logic [23:0] rsp1_ycbcr,
  output logic [1:0]  rsp1_user,
  output logic [15:0] beat_cnt0,
  output logic [15:0] beat_cnt1,
  output logic        err
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  typedef struct packed {
    logic       vld;
    logic       id;
    logic [1:0] user;
  } tag_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          gnt_vld, gnt_id;
  logic [23:0]   sel_rgb;
  logic [1:0]    sel_user;

  logic          cvt_clken_q, cvt_vsync_q, cvt_href_q;
  logic [23:0]   cvt_rgb_q;
  tag_t          tag_q [LATENCY+1];
  tag_t          tail;

  logic          rsp0_valid_q, rsp1_valid_q;
  logic [23:0]   rsp0_ycbcr_q, rsp1_ycbcr_q;
  logic [1:0]    rsp0_user_q, rsp1_user_q;
  logic [15:0]   beat_cnt0_q, beat_cnt1_q;
  logic          err_q;

  // Grant and burst bookkeeping; grants are suppressed while reset is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    unique case ({req1_valid, req0_valid})
      2'b01: begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
      2'b10: begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      2'b11: begin
        gnt_vld = 1'b1;
        unique case (state_q)
          OWN0:    gnt_id = (cnt_q < BURST_C) ? 1'b0 : 1'b1;
          OWN1:    gnt_id = (cnt_q < BURST_C) ? 1'b1 : 1'b0;
          default: gnt_id = ~last_q;
        endcase
      end
      default: ;
    endcase
    gnt_vld = gnt_vld & rst_n;

    if (gnt_vld) begin
      last_d = gnt_id;
      if ((state_q == OWN0 && !gnt_id) || (state_q == OWN1 && gnt_id)) begin
        if (cnt_q != BURST_C) cnt_d = cnt_q + 1'b1;
      end else begin
        state_d = gnt_id ? OWN1 : OWN0;
        cnt_d   = CW'(1);
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;
  assign sel_rgb    = gnt_id ? req1_rgb  : req0_rgb;
  assign sel_user   = gnt_id ? req1_user : req0_user;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Converter input stage; RGB holds between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cvt_clken_q <= 1'b0;
      cvt_vsync_q <= 1'b0;
      cvt_href_q  <= 1'b0;
      cvt_rgb_q   <= '0;
    end else if (gnt_vld) begin
      cvt_clken_q <= 1'b1;
      {cvt_vsync_q, cvt_href_q} <= sel_user;
      cvt_rgb_q   <= sel_rgb;
    end else begin
      cvt_clken_q <= 1'b0;
      cvt_vsync_q <= 1'b0;
      cvt_href_q  <= 1'b0;
    end
  end

  assign cvt_clken = cvt_clken_q;
  assign cvt_vsync = cvt_vsync_q;
  assign cvt_href  = cvt_href_q;
  assign {cvt_red, cvt_green, cvt_blue} = cvt_rgb_q;

  // Tag stage 0 is aligned with the converter input; stage LATENCY with its output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {gnt_vld, gnt_id, sel_user};
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail = tag_q[LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_ycbcr_q <= '0;
      rsp1_ycbcr_q <= '0;
      rsp0_user_q  <= '0;
      rsp1_user_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rsp0_valid_q <= tail.vld & ~tail.id;
      rsp1_valid_q <= tail.vld &  tail.id;
      if (tail.vld && !tail.id) begin
        rsp0_ycbcr_q <= {cvt_Y, cvt_Cb, cvt_Cr};
        rsp0_user_q  <= tail.user;
      end
      if (tail.vld && tail.id) begin
        rsp1_ycbcr_q <= {cvt_Y, cvt_Cb, cvt_Cr};
        rsp1_user_q  <= tail.user;
      end
      err_q <= err_q | (tail.vld ^ cvt_post_clken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt0_q <= '0;
      beat_cnt1_q <= '0;
    end else begin
      if (req0_valid && req0_ready) beat_cnt0_q <= beat_cnt0_q + 16'd1;
      if (req1_valid && req1_ready) beat_cnt1_q <= beat_cnt1_q + 16'd1;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_ycbcr = rsp0_ycbcr_q;
  assign rsp1_ycbcr = rsp1_ycbcr_q;
  assign rsp0_user  = rsp0_user_q;
  assign rsp1_user  = rsp1_user_q;
  assign beat_cnt0  = beat_cnt0_q;
  assign beat_cnt1  = beat_cnt1_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vip_ycbcr_share_arb.sv
// Bench for vip_ycbcr_share_arb: directed stimulus, queue scoreboard, negedge monitor.
// The shared converter is a stand-in LAT-deep pass-through, so each expected {Y,Cb,Cr} equals the beat's {R,G,B}.
module tb_vip_ycbcr_share_arb;

  localparam int LAT = 3;
  localparam int BUR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [23:0] req0_rgb, req1_rgb;
  logic [1:0]  req0_user, req1_user;
  logic        cvt_vsync, cvt_href, cvt_clken;
  logic [7:0]  cvt_red, cvt_green, cvt_blue;
  logic        cvt_post_clken;
  logic [7:0]  cvt_Y, cvt_Cb, cvt_Cr;
  logic        rsp0_valid, rsp1_valid;
  logic [23:0] rsp0_ycbcr, rsp1_ycbcr;
  logic [1:0]  rsp0_user, rsp1_user;
  logic [15:0] beat_cnt0, beat_cnt1;
  logic        err;
  logic        force_pc;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [23:0] d;
    logic [1:0]  u;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  vip_ycbcr_share_arb #(.LATENCY(LAT), .BURST(BUR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rgb(req0_rgb), .req0_user(req0_user),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rgb(req1_rgb), .req1_user(req1_user),
    .cvt_vsync(cvt_vsync), .cvt_href(cvt_href), .cvt_clken(cvt_clken),
    .cvt_red(cvt_red), .cvt_green(cvt_green), .cvt_blue(cvt_blue),
    .cvt_post_clken(cvt_post_clken), .cvt_Y(cvt_Y), .cvt_Cb(cvt_Cb), .cvt_Cr(cvt_Cr),
    .rsp0_valid(rsp0_valid), .rsp0_ycbcr(rsp0_ycbcr), .rsp0_user(rsp0_user),
    .rsp1_valid(rsp1_valid), .rsp1_ycbcr(rsp1_ycbcr), .rsp1_user(rsp1_user),
    .beat_cnt0(beat_cnt0), .beat_cnt1(beat_cnt1), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in converter: LAT register stages, no reset, pass-through data.
  logic [24:0] cpipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    cpipe[0] <= {cvt_clken, cvt_red, cvt_green, cvt_blue};
    for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
  end
  assign cvt_post_clken = cpipe[LAT-1][24] | force_pc;
  assign {cvt_Y, cvt_Cb, cvt_Cr} = cpipe[LAT-1][23:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; er* < 0 skips the ready comparison.
  task automatic drive(input logic v0, input logic [23:0] p0, input logic [1:0] u0,
                       input logic v1, input logic [23:0] p1, input logic [1:0] u1,
                       input int er0, input int er1);
    exp_t e;
    @(negedge clk);
    req0_valid = v0; req0_rgb = p0; req0_user = u0;
    req1_valid = v1; req1_rgb = p1; req1_user = u1;
    #1;
    if (er0 >= 0) chk("ready0", {31'b0, req0_ready}, er0);
    if (er1 >= 0) chk("ready1", {31'b0, req1_ready}, er1);
    if (v0 && req0_ready) begin
      e.d = p0; e.u = u0; e.due = cyc + LAT + 2;
      q0.push_back(e);
    end
    if (v1 && req1_ready) begin
      e.d = p1; e.u = u1; e.due = cyc + LAT + 2;
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 24'h0, 2'b0, 1'b0, 24'h0, 2'b0, -1, -1);
  endtask

  always @(negedge clk) begin
    if (rsp0_valid) begin
      if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
      else begin
        m0 = q0.pop_front();
        chk("rsp0_ycbcr", {8'b0, rsp0_ycbcr}, {8'b0, m0.d});
        chk("rsp0_user", {30'b0, rsp0_user}, {30'b0, m0.u});
        chk("rsp0_latency", cyc, m0.due);
      end
    end
    if (rsp1_valid) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        m1 = q1.pop_front();
        chk("rsp1_ycbcr", {8'b0, rsp1_ycbcr}, {8'b0, m1.d});
        chk("rsp1_user", {30'b0, rsp1_user}, {30'b0, m1.u});
        chk("rsp1_latency", cyc, m1.due);
      end
    end
  end

  initial begin
    rst_n = 1'b0; force_pc = 1'b0;
    req0_valid = 1'b1; req0_rgb = 24'h0; req0_user = 2'b0;
    req1_valid = 1'b1; req1_rgb = 24'h0; req1_user = 2'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_ready0", {31'b0, req0_ready}, 0);
    chk("rst_ready1", {31'b0, req1_ready}, 0);
    chk("rst_clken", {31'b0, cvt_clken}, 0);
    chk("rst_sync", {30'b0, cvt_vsync, cvt_href}, 0);
    chk("rst_rgb", {8'b0, cvt_red, cvt_green, cvt_blue}, 0);
    chk("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp0_ycbcr", {8'b0, rsp0_ycbcr}, 0);
    chk("rst_beat_cnt", {beat_cnt1, beat_cnt0}, 0);
    chk("rst_err", {31'b0, err}, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    // Both requesters valid 16 cycles: bursts of 4, req0 first out of reset.
    for (int i = 0; i < 16; i++)
      drive(1'b1, {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)}, 2'(i),
            1'b1, {8'h80 + 8'(i), 8'h90 + 8'(i), 8'hA0 + 8'(i)}, ~2'(i),
            (i % 8) < 4 ? 1 : 0, (i % 8) < 4 ? 0 : 1);
    idle(8);
    chk("burst_q0_drained", q0.size(), 0);
    chk("burst_q1_drained", q1.size(), 0);
    chk("burst_cnt0", {16'b0, beat_cnt0}, 8);
    chk("burst_cnt1", {16'b0, beat_cnt1}, 8);

    // req0 alone.
    drive(1'b1, 24'hFF0000, 2'b11, 1'b0, 24'h0, 2'b0, 1, 0);
    idle(8);
    chk("solo_q0_drained", q0.size(), 0);
    chk("solo_cnt0", {16'b0, beat_cnt0}, 9);

    // last=0 now: contention from idle goes to req1; then req1 saturates its run.
    drive(1'b1, 24'h010203, 2'b01, 1'b1, 24'h040506, 2'b10, 0, 1);
    for (int i = 0; i < 5; i++)
      drive(1'b0, 24'h0, 2'b0, 1'b1, {8'hC0 + 8'(i), 8'hD0, 8'hE0}, 2'b01, 0, 1);
    drive(1'b1, 24'h111213, 2'b10, 1'b1, 24'h212223, 2'b11, 1, 0);
    drive(1'b1, 24'h313233, 2'b01, 1'b1, 24'h414243, 2'b00, 1, 0);
    idle(8);
    chk("rr_q0_drained", q0.size(), 0);
    chk("rr_q1_drained", q1.size(), 0);
    chk("rr_cnt0", {16'b0, beat_cnt0}, 11);
    chk("rr_cnt1", {16'b0, beat_cnt1}, 14);

    // Spurious converter enable with nothing in flight.
    chk("err_before", {31'b0, err}, 0);
    @(negedge clk); force_pc = 1'b1;
    @(negedge clk); force_pc = 1'b0;
    #1 chk("err_set", {31'b0, err}, 1);
    idle(3);
    chk("err_sticky", {31'b0, err}, 1);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      drive(1'b1, {8'h55, 8'h66, 8'(i)}, 2'b01, 1'b0, 24'h0, 2'b0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready0", {31'b0, req0_ready}, 0);
    chk("midrst_clken", {31'b0, cvt_clken}, 0);
    chk("midrst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 0);
    chk("midrst_beat_cnt", {beat_cnt1, beat_cnt0}, 0);
    chk("midrst_err", {31'b0, err}, 0);
    q0.delete();
    q1.delete();
    repeat (5) @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    idle(10);
    chk("postrst_err", {31'b0, err}, 0);
    chk("postrst_cnt0", {16'b0, beat_cnt0}, 0);

    // 65536 req1 beats: counter wraps back to 0.
    for (int i = 0; i < 65536; i++)
      drive(1'b0, 24'h0, 2'b0, 1'b1, {i[7:0], ~i[7:0], i[15:8]}, i[1:0], -1, 1);
    idle(8);
    chk("wrap_cnt1", {16'b0, beat_cnt1}, 0);
    chk("wrap_cnt0", {16'b0, beat_cnt0}, 0);
    chk("wrap_err", {31'b0, err}, 0);
    chk("wrap_q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
